// File: rtl/sparc_fpq_pkg.sv
// ---------------------------------------------------------------------------
// sparc_fpq_pkg
// Shared constants for the FFU FPop request queue (sparc_ffu_fpop_pcxq):
//   FP_RTN       - CPX return type that completes an FP operation
//   N_THREADS    - number of hardware threads tracked (one busy bit each)
//   TID_W        - thread id width
//   FPOP_DATA_W  - default FPop payload width (matches ffu_lsu_data)
//   is_fp_rtn()  - decode of a CPX FP-completion return
// ---------------------------------------------------------------------------
package sparc_fpq_pkg;

    localparam logic [3:0] FP_RTN      = 4'b1000;
    localparam int         N_THREADS   = 4;
    localparam int         TID_W       = 2;
    localparam int         FPOP_DATA_W = 81;

    function automatic logic is_fp_rtn(input logic vld, input logic [3:0] req);
        return vld && (req == FP_RTN);
    endfunction

endpackage

// File: rtl/sparc_ffu_fpop_pcxq_if.sv
// ---------------------------------------------------------------------------
// sparc_ffu_fpop_pcxq_if
// Bundles every non-clock signal of the FPop request queue.
//   FFU side : ffu_lsu_fpop_rq_vld, ffu_lsu_data, ffu_lsu_fpop_tid, lsu_ffu_ack
//   PCX side : fpq_pcx_req, fpq_pcx_data, fpq_pcx_tid, pcx_fpq_grant
//   CPX side : cpx_vld, cpx_req, cpx_fpq_tid
//   Status   : fpq_busy, fpq_idle, fpq_err, fpq_err_timeout
// Modports:
//   slave  - the queue itself
//   master - the environment (FFU + PCX arbiter + CPX)
//
// Handshakes:
//   FFU -> queue: the FFU raises ffu_lsu_fpop_rq_vld with stable data/tid and
//     holds it until lsu_ffu_ack pulses for one cycle; the packet was taken at
//     the edge that raised the ack.
//   queue -> PCX: fpq_pcx_req is high while the head is valid; the head is
//     consumed at any edge where fpq_pcx_req and pcx_fpq_grant are both high.
// ---------------------------------------------------------------------------
interface sparc_ffu_fpop_pcxq_if
    import sparc_fpq_pkg::*;
#(
    parameter int DATA_W = FPOP_DATA_W
) ();

    logic                 ffu_lsu_fpop_rq_vld;
    logic [DATA_W-1:0]    ffu_lsu_data;
    logic [TID_W-1:0]     ffu_lsu_fpop_tid;
    logic                 lsu_ffu_ack;

    logic                 fpq_pcx_req;
    logic [DATA_W-1:0]    fpq_pcx_data;
    logic [TID_W-1:0]     fpq_pcx_tid;
    logic                 pcx_fpq_grant;

    logic                 cpx_vld;
    logic [3:0]           cpx_req;
    logic [TID_W-1:0]     cpx_fpq_tid;

    logic [N_THREADS-1:0] fpq_busy;
    logic                 fpq_idle;
    logic                 fpq_err;
    logic                 fpq_err_timeout;

    modport slave (
        input  ffu_lsu_fpop_rq_vld, ffu_lsu_data, ffu_lsu_fpop_tid,
        output lsu_ffu_ack,
        output fpq_pcx_req, fpq_pcx_data, fpq_pcx_tid,
        input  pcx_fpq_grant,
        input  cpx_vld, cpx_req, cpx_fpq_tid,
        output fpq_busy, fpq_idle, fpq_err, fpq_err_timeout
    );

    modport master (
        output ffu_lsu_fpop_rq_vld, ffu_lsu_data, ffu_lsu_fpop_tid,
        input  lsu_ffu_ack,
        input  fpq_pcx_req, fpq_pcx_data, fpq_pcx_tid,
        output pcx_fpq_grant,
        output cpx_vld, cpx_req, cpx_fpq_tid,
        input  fpq_busy, fpq_idle, fpq_err, fpq_err_timeout
    );

endinterface

// File: rtl/sparc_fpq_fifo.sv
// ---------------------------------------------------------------------------
// sparc_fpq_fifo
// DEPTH x W register FIFO. Head is read combinationally from the read pointer.
// Ports:
//   clk, rst   - clock, synchronous active-high reset (pointers/count only)
//   push,wdata - write wdata at the tail (ignored when full)
//   pop        - advance the head (ignored when empty)
//   rdata      - current head entry
//   count      - number of valid entries
//   full,empty - derived from count
// DEPTH must be a power of two >= 2 so pointers wrap by natural overflow.
// ---------------------------------------------------------------------------
module sparc_fpq_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 83
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [W-1:0]               wdata,
    input  logic                       pop,
    output logic [W-1:0]               rdata,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int                PTR_W    = $clog2(DEPTH);
    localparam int                CNT_W    = PTR_W + 1;
    localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DEPTH);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is not reset; contents are only observed once written.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/sparc_ffu_fpop_pcxq.sv
// ---------------------------------------------------------------------------
// sparc_ffu_fpop_pcxq
// FPop request queue between the FFU and the PCX arbiter. Accepts FPop packets
// from the FFU (registered one-cycle ack), buffers them in a small FIFO, offers
// the head to PCX with req/grant, and tracks one outstanding FP operation per
// thread until the matching CPX FP_RTN return.
// Ports:
//   rclk   - core clock
//   reset  - synchronous active-high reset
//   bus    - sparc_ffu_fpop_pcxq_if.slave (FFU, PCX, CPX and status signals)
// Parameters:
//   DEPTH  - queue entries (power of two, >= 2)
//   DATA_W - payload width; must equal the interface's DATA_W
// Build option:
//   FPQ_WATCHDOG_EN - adds a 12-bit watchdog that raises sticky
//                     fpq_err_timeout when some thread stays busy for 4095
//                     cycles with no FP return; otherwise the flag is tied 0.
// ---------------------------------------------------------------------------
module sparc_ffu_fpop_pcxq
    import sparc_fpq_pkg::*;
#(
    parameter int DEPTH  = 2,
    parameter int DATA_W = FPOP_DATA_W
) (
    input  logic                   rclk,
    input  logic                   reset,
    sparc_ffu_fpop_pcxq_if.slave   bus
);

    localparam int ENTRY_W = DATA_W + TID_W;

    logic [N_THREADS-1:0]   busy;
    logic [N_THREADS-1:0]   busy_nxt;
    logic                   ack;
    logic                   err;

    logic                   q_full;
    logic                   q_empty;
    logic [$clog2(DEPTH):0] q_count;
    logic [ENTRY_W-1:0]     q_head;

    logic                   accept;
    logic                   dequeue;
    logic                   rtn;
    logic                   rtn_clr;
    logic                   rtn_bad;

    // The !ack term stops a second accept of the same packet in the cycle the
    // FFU sees the ack but has not yet dropped valid.
    assign accept  = bus.ffu_lsu_fpop_rq_vld && !q_full &&
                     !busy[bus.ffu_lsu_fpop_tid] && !ack;
    assign dequeue = !q_empty && bus.pcx_fpq_grant;

    assign rtn     = is_fp_rtn(bus.cpx_vld, bus.cpx_req);
    assign rtn_clr = rtn && busy[bus.cpx_fpq_tid];
    assign rtn_bad = rtn && !busy[bus.cpx_fpq_tid];

    sparc_fpq_fifo #(
        .DEPTH (DEPTH),
        .W     (ENTRY_W)
    ) u_fifo (
        .clk   (rclk),
        .rst   (reset),
        .push  (accept),
        .wdata ({bus.ffu_lsu_fpop_tid, bus.ffu_lsu_data}),
        .pop   (dequeue),
        .rdata (q_head),
        .count (q_count),
        .full  (q_full),
        .empty (q_empty)
    );

    // Set and clear never target the same thread in one edge: accept needs
    // !busy and a clear needs busy. Different threads both apply.
    always_comb begin
        busy_nxt = busy;
        if (accept)  busy_nxt[bus.ffu_lsu_fpop_tid] = 1'b1;
        if (rtn_clr) busy_nxt[bus.cpx_fpq_tid]      = 1'b0;
    end

    always_ff @(posedge rclk) begin
        if (reset) begin
            ack  <= 1'b0;
            busy <= '0;
            err  <= 1'b0;
        end else begin
            ack  <= accept;
            busy <= busy_nxt;
            if ((bus.pcx_fpq_grant && q_empty) || rtn_bad) err <= 1'b1;
        end
    end

    assign bus.lsu_ffu_ack  = ack;
    assign bus.fpq_pcx_req  = !q_empty;
    assign bus.fpq_pcx_tid  = q_head[ENTRY_W-1 -: TID_W];
    assign bus.fpq_pcx_data = q_head[DATA_W-1:0];
    assign bus.fpq_busy     = busy;
    assign bus.fpq_idle     = (q_count == '0) && (busy == '0);
    assign bus.fpq_err      = err;

`ifdef FPQ_WATCHDOG_EN
    logic [11:0] wd_cnt;
    logic        wd_err;

    // Counts cycles spent with work outstanding and no FP completion; the
    // flag rises on the edge the counter reaches its maximum, which it then
    // holds until a return or an idle busy vector restarts it.
    always_ff @(posedge rclk) begin
        if (reset) begin
            wd_cnt <= '0;
            wd_err <= 1'b0;
        end else if (rtn || (busy == '0)) begin
            wd_cnt <= '0;
        end else if (wd_cnt != 12'hfff) begin
            wd_cnt <= wd_cnt + 12'd1;
            if (wd_cnt == 12'hffe) wd_err <= 1'b1;
        end
    end

    assign bus.fpq_err_timeout = wd_err;
`else
    assign bus.fpq_err_timeout = 1'b0;
`endif

endmodule
